// File: rtl/count_checker.sv
// Monitor for the output bus of a free-running WIDTH-bit up counter.
// Locks onto the +1 sequence, flags mismatches, counts errors and wrap-arounds.
module count_checker #(
    parameter int WIDTH          = 4,
    parameter int LOCK_CYCLES    = 2,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int WRAP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      clear_err,
    input  logic [WIDTH-1:0]          q_in,
    output logic                      locked,
    output logic                      mismatch,
    output logic [WIDTH-1:0]          expected,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic                      sticky_err,
    output logic [WRAP_CNT_WIDTH-1:0] wrap_count
);

    localparam int MC_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [MC_W-1:0]          MC_LOCK  = MC_W'(LOCK_CYCLES);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ZERO = {ERR_CNT_WIDTH{1'b0}};

    // Error counter sticks at all-ones instead of rolling back to zero.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        if (v == ERR_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERR_ONE;
        end
    endfunction

    logic [1:0]                state_r,      state_s;
    logic [WIDTH-1:0]          prev_r,       prev_s;
    logic [MC_W-1:0]           match_cnt_r,  match_cnt_s;
    logic                      locked_r,     locked_s;
    logic                      mismatch_r,   mismatch_s;
    logic [WIDTH-1:0]          expected_r,   expected_s;
    logic [ERR_CNT_WIDTH-1:0]  err_count_r,  err_count_s;
    logic                      sticky_err_r, sticky_err_s;
    logic [WRAP_CNT_WIDTH-1:0] wrap_count_r, wrap_count_s;
    logic                      hit_s;

    // Next-state and next-output computation for the lock/check FSM.
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        match_cnt_s  = match_cnt_r;
        mismatch_s   = 1'b0;
        expected_s   = expected_r;
        err_count_s  = err_count_r;
        sticky_err_s = sticky_err_r;
        wrap_count_s = wrap_count_r;
        hit_s        = (q_in == expected_r);

        if (!enable) begin
            state_s     = ST_IDLE;
            match_cnt_s = {MC_W{1'b0}};
        end else begin
            prev_s = q_in;
            case (state_r)
                ST_IDLE: begin
                    state_s     = ST_ACQUIRE;
                    match_cnt_s = {MC_W{1'b0}};
                end
                ST_ACQUIRE: begin
                    if (hit_s) begin
                        match_cnt_s = match_cnt_r + MC_W'(1);
                        if (match_cnt_s == MC_LOCK) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s = ST_ACQUIRE;
                        end
                    end else begin
                        match_cnt_s = {MC_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (hit_s) begin
                        if (q_in == {WIDTH{1'b0}}) begin
                            wrap_count_s = wrap_count_r + WRAP_CNT_WIDTH'(1);
                        end else begin
                            wrap_count_s = wrap_count_r;
                        end
                    end else begin
                        mismatch_s   = 1'b1;
                        err_count_s  = sat_inc(err_count_r);
                        sticky_err_s = 1'b1;
                        state_s      = ST_ACQUIRE;
                        match_cnt_s  = {MC_W{1'b0}};
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    match_cnt_s = {MC_W{1'b0}};
                end
            endcase
            expected_s = prev_s + WIDTH'(1);
        end

        // A mismatch on the clearing edge survives as the first new error.
        if (clear_err) begin
            if (mismatch_s) begin
                err_count_s  = ERR_ONE;
                sticky_err_s = 1'b1;
            end else begin
                err_count_s  = ERR_ZERO;
                sticky_err_s = 1'b0;
            end
        end else begin
            err_count_s  = err_count_s;
            sticky_err_s = sticky_err_s;
        end

        locked_s = (state_s == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            prev_r       <= {WIDTH{1'b0}};
            match_cnt_r  <= {MC_W{1'b0}};
            locked_r     <= 1'b0;
            mismatch_r   <= 1'b0;
            expected_r   <= {WIDTH{1'b0}};
            err_count_r  <= ERR_ZERO;
            sticky_err_r <= 1'b0;
            wrap_count_r <= {WRAP_CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            prev_r       <= prev_s;
            match_cnt_r  <= match_cnt_s;
            locked_r     <= locked_s;
            mismatch_r   <= mismatch_s;
            expected_r   <= expected_s;
            err_count_r  <= err_count_s;
            sticky_err_r <= sticky_err_s;
            wrap_count_r <= wrap_count_s;
        end
    end

    assign locked     = locked_r;
    assign mismatch   = mismatch_r;
    assign expected   = expected_r;
    assign err_count  = err_count_r;
    assign sticky_err = sticky_err_r;
    assign wrap_count = wrap_count_r;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed scenarios then random traffic, both checked
// against an arithmetic reference model of the lock/check rules.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       locked, mismatch, sticky_err;
    logic [3:0] expected;
    logic [7:0] err_count, wrap_count;

    logic       e2_locked, e2_mismatch, e2_sticky_err;
    logic [3:0] e2_expected;
    logic [1:0] e2_err_count;
    logic [7:0] e2_wrap_count;

    int tests = 0;
    int fails = 0;

    count_checker #(.WIDTH(4), .LOCK_CYCLES(2), .ERR_CNT_WIDTH(8), .WRAP_CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear_err(clear_err), .q_in(q_in),
        .locked(locked), .mismatch(mismatch), .expected(expected), .err_count(err_count),
        .sticky_err(sticky_err), .wrap_count(wrap_count)
    );

    count_checker #(.WIDTH(4), .LOCK_CYCLES(2), .ERR_CNT_WIDTH(2), .WRAP_CNT_WIDTH(8)) dut_e2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear_err(clear_err), .q_in(q_in),
        .locked(e2_locked), .mismatch(e2_mismatch), .expected(e2_expected), .err_count(e2_err_count),
        .sticky_err(e2_sticky_err), .wrap_count(e2_wrap_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 acquiring, 2 locked.
    int m_mode, m_prev, m_exp, m_run, m_errs, m_wraps;
    bit m_sticky, m_mm;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_exp = 0; m_run = 0;
        m_errs = 0; m_wraps = 0; m_sticky = 0; m_mm = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input int q);
        m_mm = 0;
        if (!en) begin
            m_mode = 0;
            m_run  = 0;
        end else begin
            if (m_mode == 0) begin
                m_mode = 1;
                m_run  = 0;
            end else if (m_mode == 1) begin
                if (q == m_exp) begin
                    m_run = m_run + 1;
                    if (m_run >= 2) m_mode = 2;
                end else begin
                    m_run = 0;
                end
            end else begin
                if (q == m_exp) begin
                    if (q == 0) m_wraps = m_wraps + 1;
                end else begin
                    m_mm = 1; m_errs = m_errs + 1; m_sticky = 1; m_mode = 1; m_run = 0;
                end
            end
            m_prev = q;
            m_exp  = (m_prev + 1) % 16;
        end
        if (clr) begin
            m_errs   = m_mm ? 1 : 0;
            m_sticky = m_mm;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int e8, e2;
        e8 = (m_errs > 255) ? 255 : m_errs;
        e2 = (m_errs > 3) ? 3 : m_errs;
        chk("locked",      32'(locked),      32'(m_mode == 2));
        chk("mismatch",    32'(mismatch),    32'(m_mm));
        chk("expected",    32'(expected),    32'(m_exp));
        chk("err_count",   32'(err_count),   32'(e8));
        chk("sticky_err",  32'(sticky_err),  32'(m_sticky));
        chk("wrap_count",  32'(wrap_count),  32'(m_wraps % 256));
        chk("e2_err",      32'(e2_err_count), 32'(e2));
        chk("e2_sticky",   32'(e2_sticky_err), 32'(m_sticky));
        chk("e2_locked",   32'(e2_locked),   32'(m_mode == 2));
        chk("e2_mismatch", 32'(e2_mismatch), 32'(m_mm));
        chk("e2_expected", 32'(e2_expected), 32'(m_exp));
        chk("e2_wrap",     32'(e2_wrap_count), 32'(m_wraps % 256));
    endtask

    task automatic tick(input bit en, input bit clr, input int q);
        enable    = en;
        clear_err = clr;
        q_in      = 4'(q);
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(en, clr, q % 16);
        #1;
        check_all();
    endtask

    initial begin
        int c;
        int w0;
        model_reset();

        // 1. Reset held: outputs stay zero whatever the inputs do.
        for (int i = 0; i < 4; i++) tick(i[0], 1'b0, i * 3 + 1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err",    32'(err_count), 32'd0);
        #3 reset_n = 1'b1;

        // 2. Acquire lock on 3,4,5.
        tick(1, 0, 3);
        tick(1, 0, 4);
        chk("acq_not_locked", 32'(locked), 32'd0);
        tick(1, 0, 5);
        chk("lock_after_5", 32'(locked), 32'd1);
        chk("exp_6", 32'(expected), 32'd6);

        // 3. Count through the wrap.
        for (int v = 6; v <= 15; v++) tick(1, 0, v);
        w0 = 32'(wrap_count);
        tick(1, 0, 0);
        chk("wrap_inc", 32'(wrap_count), 32'(w0 + 1));
        chk("wrap_one", 32'(wrap_count), 32'd1);
        tick(1, 0, 1);
        chk("wrap_hold", 32'(wrap_count), 32'(w0 + 1));

        // 4. Expected 7, jump to 9,10,11.
        for (int v = 2; v <= 6; v++) tick(1, 0, v);
        chk("exp_7", 32'(expected), 32'd7);
        tick(1, 0, 9);
        chk("mm_pulse", 32'(mismatch), 32'd1);
        chk("err_1", 32'(err_count), 32'd1);
        chk("sticky_1", 32'(sticky_err), 32'd1);
        chk("unlocked", 32'(locked), 32'd0);
        tick(1, 0, 10);
        chk("mm_gone", 32'(mismatch), 32'd0);
        tick(1, 0, 11);
        chk("relock", 32'(locked), 32'd1);

        // 5. Four more errors, relocking between each; 2-bit counter saturates.
        c = 11;
        for (int k = 0; k < 4; k++) begin
            c = c + 5; tick(1, 0, c);
            c = c + 1; tick(1, 0, c);
            c = c + 1; tick(1, 0, c);
        end
        chk("sat_e2", 32'(e2_err_count), 32'd3);
        chk("err_5", 32'(err_count), 32'd5);
        c = c + 5; tick(1, 1, c);
        chk("clr_mm_e2", 32'(e2_err_count), 32'd1);
        chk("clr_mm_err", 32'(err_count), 32'd1);
        chk("clr_mm_sticky", 32'(sticky_err), 32'd1);
        c = c + 1; tick(1, 0, c);
        c = c + 1; tick(1, 0, c);

        // 6. Enable gap while counting continues.
        for (int k = 0; k < 3; k++) begin
            c = c + 1; tick(0, 0, c);
            chk("gap_unlocked", 32'(locked), 32'd0);
            chk("gap_err_hold", 32'(err_count), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            c = c + 1; tick(1, 0, c);
        end
        chk("gap_relock", 32'(locked), 32'd1);

        // Plain clear without an error.
        c = c + 1; tick(1, 1, c);
        chk("clr_err0", 32'(err_count), 32'd0);
        chk("clr_sticky0", 32'(sticky_err), 32'd0);

        // Async reset asserted between edges clears outputs at once.
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset_n = 1'b1;

        // Random traffic: mostly counting, occasional jumps, gaps and clears.
        c = $urandom_range(0, 15);
        for (int n = 0; n < 600; n++) begin
            bit en, clr;
            c = c + 1;
            if ($urandom_range(0, 9) == 0) c = $urandom_range(0, 15);
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 29) == 0);
            tick(en, clr, c % 16);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
